// File: rtl/uart_rx_x16.sv
// UART receive core: 16x oversampled line, 3-sample majority per bit.
// Delivers each frame with parity, framing and break status.
module uart_rx_x16 #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick_x16,
  input  logic                  i_RX,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_busy
);

  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_m, rx_s;
  logic                  armed_q, armed_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [2:0]            smp_q, smp_d;
  logic                  par_q, par_d;
  logic                  perr_q, perr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d;
  logic                  pe_d;
  logic                  fe_d;
  logic                  bk_d;
  logic                  s2;
  logic                  maj;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_RX;
      rx_s <= rx_m;
    end
  end

  // At STOP the vote closes on count 9, so the live sample stands in.
  assign s2  = (cnt_q == 4'd9) ? rx_s : smp_q[2];
  assign maj = (smp_q[0] & smp_q[1])
             | (smp_q[0] & s2)
             | (smp_q[1] & s2);

  assign o_busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    smp_d   = smp_q;
    par_d   = par_q;
    perr_d  = perr_q;
    armed_d = armed_q | rx_s;
    data_d  = o_data;
    valid_d = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    bk_d    = 1'b0;
    if (i_tick_x16) begin
      if (state_q != IDLE) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) smp_d[0] = rx_s;
        if (cnt_q == 4'd8) smp_d[1] = rx_s;
        if (cnt_q == 4'd9) smp_d[2] = rx_s;
      end
      unique case (state_q)
        IDLE: begin
          // detect tick is position 0 of the start bit
          if (armed_q && !rx_s) begin
            state_d = START;
            cnt_d   = 4'd1;
            par_d   = 1'b0;
            perr_d  = 1'b0;
          end
        end
        START: begin
          if (cnt_q == 4'd15) begin
            if (maj) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              idx_d   = '0;
            end
          end
        end
        DATA: begin
          if (cnt_q == 4'd15) begin
            sh_d = {maj, sh_q[DATA_WIDTH-1:1]};
            if (idx_q == IW'(DATA_WIDTH - 1)) begin
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (cnt_q == 4'd15) begin
            par_d   = maj;
            perr_d  = maj ^ (^sh_q) ^ PARITY_ODD;
            state_d = STOP;
          end
        end
        STOP: begin
          if (cnt_q == 4'd9) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            valid_d = 1'b1;
            data_d  = sh_q;
            pe_d    = perr_q;
            fe_d    = !maj;
            bk_d    = !maj && (sh_q == '0)
                    && !(PARITY_EN && par_q);
            if (!maj) armed_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      smp_q        <= '0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      smp_q        <= smp_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      o_data       <= data_d;
      o_valid      <= valid_d;
      o_parity_err <= pe_d;
      o_frame_err  <= fe_d;
      o_break      <= bk_d;
    end
  end

endmodule

// File: doc/uart_rx_x16.md
# uart_rx_x16

Receive-side serial core for the UART: converts the asynchronous line into parallel bytes using 16x oversampling with 3-sample majority voting. It complements the transmitter inside `uart`. It sits between the pin `i_RX` and the RX FIFO write port. It consumes the x16 tick from the baud generator (`i_divisor_x16`/`i_fra_adj_x16` path) and reports per-frame parity, framing and break status that feeds `o_uart_rx_error`.

## Interface
- DATA_WIDTH, 8, data bits per frame (5–9)
- PARITY_EN, 0, 1 = a parity bit follows the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_tick_x16  in  1  one-cycle strobe at 16x baud rate
- i_RX  in  1  asynchronous serial line, idle high
- o_data  out  DATA_WIDTH  last received word, held until next frame completes
- o_valid  out  1  one-cycle strobe, o_data and flags are valid
- o_parity_err  out  1  parity mismatch for the frame qualified by o_valid
- o_frame_err  out  1  stop bit sampled low for the frame qualified by o_valid
- o_break  out  1  frame_err with all data bits 0 and parity bit 0 (if enabled)
- o_busy  out  1  high in any state other than IDLE

## Operation
- i_RX passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- After reset, an `armed` flag is cleared. It sets on the first `rx_s==1`. No start bit is detected while it is clear.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit `tick_cnt`, a bit index, and a shift register advance only on cycles where i_tick_x16=1.
- IDLE: on a tick with `armed` and `rx_s==0`, go to START with tick_cnt=0. That tick counts as sample position 0.
- Every bit period spans tick_cnt 0..15. `rx_s` is captured at counts 7, 8 and 9. The bit value is the majority of the 3 samples.
- START: at count 15, majority 1 means a false start and the FSM returns to IDLE with no output. Majority 0 moves to DATA with tick_cnt=0 and bit index 0.
- DATA: bits arrive LSB first. At count 15 the majority is shifted in. After bit DATA_WIDTH-1 the FSM goes to PARITY if PARITY_EN, otherwise to STOP.
- PARITY: at count 15 the sampled bit is compared with the XOR of the data bits (inverted when PARITY_ODD), then the FSM goes to STOP.
- STOP: at count 9, the stop-bit majority is evaluated and the FSM returns to IDLE immediately. The early exit absorbs up to 6/16 bit of clock drift per frame.
- A frame with errors is still delivered: o_valid=1 with the error flags set.
- Break condition: frame_err and all data bits 0 (and parity bit 0 when enabled). It sets o_break.
- After a break or frame error, `armed` clears. A new start is only accepted after `rx_s==1` is seen again, so a held-low line produces exactly one frame.
- Reset at any point (mid-frame included): FSM to IDLE, counters to 0, and the partial frame is discarded with no o_valid.

## Timing
- Reset values: o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_break=0, o_busy=0.
- The synchronizer adds 2 i_clk cycles from i_RX to `rx_s`.
- o_valid, o_data and the flags update in the i_clk cycle after the tick at STOP count 9. o_valid is high for exactly 1 cycle.
- The error flags are valid only when o_valid=1 and clear to 0 on the next cycle.
- o_busy rises the cycle after the start-detect tick and falls together with the o_valid assertion.
- i_tick_x16 held high continuously is legal: every cycle is a tick.
- Back-to-back frames: a falling edge at the first tick after STOP exit is detected. There is no dead time beyond the remaining stop-bit ticks.
- If i_rst and i_tick_x16 are asserted in the same cycle, reset wins.

## Test plan
All scenarios use a tick every 4 i_clk cycles (64 clocks per bit) and DATA_WIDTH=8 unless stated.

1. Frame 0xA5, no parity, stop=1 -> one o_valid pulse, o_data=0xA5, all error flags 0. o_valid lands 2 + (1+8)·64 + 9·4 + 1 cycles after the falling edge (±4 tick phase).
2. Start glitch: RX low for 6 ticks, then high -> no o_valid, o_busy returns to 0 at the end of START, FSM is IDLE.
3. Frame 0x3C with the stop bit driven low, line high afterwards -> o_valid=1, o_data=0x3C, o_frame_err=1, o_break=0.
4. PARITY_EN=1, PARITY_ODD=0, data 0x07 with parity bit 0 (correct value is 1) -> o_parity_err=1, o_data=0x07. The same frame with parity 1 gives o_parity_err=0.
5. Break: RX held low for 3 frame times, then high; a frame 0x81 follows -> exactly one break frame (o_data=0x00, o_frame_err=1, o_break=1), then o_data=0x81 with no errors.
6. i_rst pulse during DATA bit 3, then frames 0x5A and 0xC3 sent back-to-back -> no o_valid for the aborted frame, then two o_valid pulses with 0x5A and 0xC3 and no errors.
